// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared defaults and types for the decade counter digit
package counter_pkg;

    localparam int DEFAULT_WIDTH     = 4;
    localparam int DEFAULT_MAX_COUNT = 9;

    typedef logic [DEFAULT_WIDTH-1:0] cnt_t;

endpackage

// File: rtl/counter_0_to_9.sv
// rtl/counter_0_to_9.sv - modulo-(MAX_COUNT+1) up-counter digit with registered valid flag
// Optional terminal-count output tc enabled by COUNTER_0_TO_9_TC_EN.
module counter_0_to_9
    import counter_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MAX_COUNT = DEFAULT_MAX_COUNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             vld
`ifdef COUNTER_0_TO_9_TC_EN
    ,
    output logic             tc
`endif
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] cnt_next;

    // Values above LAST are treated like LAST so a corrupted state recovers to 0.
    always_comb begin
        cnt_next = cnt;
        if (en) begin
            cnt_next = (cnt >= LAST) ? '0 : cnt + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            vld <= 1'b0;
        end else begin
            cnt <= cnt_next;
            vld <= en;
        end
    end

`ifdef COUNTER_0_TO_9_TC_EN
    // Combinational on en so the next digit's enable sees the carry in the same cycle.
    assign tc = !rst && en && (cnt == LAST);
`endif

endmodule

// File: tb/tb_counter_0_to_9.sv
// tb/tb_counter_0_to_9.sv - randomized self-checking bench for counter_0_to_9
module tb_counter_0_to_9;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [3:0] cnt;
    logic       vld;

    int total = 0;
    int bad   = 0;
    int model_cnt = 0;
    logic model_vld = 1'b0;

    always #5 clk = ~clk;

`ifdef COUNTER_0_TO_9_TC_EN
    logic       tc;
    logic       tc_tens;
    logic [3:0] cnt_tens;
    logic       vld_tens;
    int         model_total = 0;

    counter_0_to_9 dut (
        .clk(clk), .rst(rst), .en(en), .cnt(cnt), .vld(vld), .tc(tc)
    );
    counter_0_to_9 dut_tens (
        .clk(clk), .rst(rst), .en(tc), .cnt(cnt_tens), .vld(vld_tens), .tc(tc_tens)
    );
`else
    counter_0_to_9 dut (
        .clk(clk), .rst(rst), .en(en), .cnt(cnt), .vld(vld)
    );
`endif

    // Drive en for one edge and advance the reference; returns at the following negedge.
    task automatic step(input logic e);
        en = e;
        @(posedge clk);
        if (e) model_cnt = (model_cnt + 1) % 10;
        model_vld = e;
`ifdef COUNTER_0_TO_9_TC_EN
        if (e) model_total = model_total + 1;
`endif
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        model_cnt = 0;
        model_vld = 1'b0;
`ifdef COUNTER_0_TO_9_TC_EN
        model_total = 0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (cnt !== 4'd0 || vld !== 1'b0) begin
            bad++;
            $display("FAIL reset_async cnt=%0d vld=%0b expected cnt=0 vld=0", cnt, vld);
        end
        #11 en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (cnt !== 4'd0 || vld !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold cnt=%0d vld=%0b expected cnt=0 vld=0", cnt, vld);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        model_cnt = 0;
        model_vld = 1'b0;
    endtask

    task automatic test_count_sequence();
        for (int i = 1; i <= 12; i++) begin
            step(1'b1);
            total++;
            if (cnt !== 4'(i % 10) || vld !== 1'b1) begin
                bad++;
                $display("FAIL count_seq edge=%0d cnt=%0d vld=%0b expected cnt=%0d vld=1",
                         i, cnt, vld, i % 10);
            end
        end
    endtask

    task automatic test_wrap();
        int wraps;
        logic [3:0] prev;
        do_reset();
        wraps = 0;
        prev  = cnt;
        for (int i = 0; i < 25; i++) begin
            step(1'b1);
            if (cnt < prev) wraps++;
            prev = cnt;
            total++;
            if (cnt > 4'd9 || cnt !== 4'(model_cnt)) begin
                bad++;
                $display("FAIL wrap_edge edge=%0d cnt=%0d expected %0d", i, cnt, model_cnt);
            end
        end
        total++;
        if (cnt !== 4'd5 || wraps != 2) begin
            bad++;
            $display("FAIL wrap_final cnt=%0d wraps=%0d expected cnt=5 wraps=2", cnt, wraps);
        end
    endtask

    task automatic test_hold();
        do_reset();
        repeat (4) step(1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0);
            total++;
            if (cnt !== 4'd4 || vld !== 1'b0) begin
                bad++;
                $display("FAIL hold cycle=%0d cnt=%0d vld=%0b expected cnt=4 vld=0", i, cnt, vld);
            end
        end
        step(1'b1);
        total++;
        if (cnt !== 4'd5 || vld !== 1'b1) begin
            bad++;
            $display("FAIL hold_resume cnt=%0d vld=%0b expected cnt=5 vld=1", cnt, vld);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (7) step(1'b1);
        #2 rst = 1'b1;
        #1;
        total++;
        if (cnt !== 4'd0 || vld !== 1'b0) begin
            bad++;
            $display("FAIL async_mid cnt=%0d vld=%0b expected cnt=0 vld=0", cnt, vld);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_cnt = 0;
        model_vld = 1'b0;
        step(1'b1);
        total++;
        if (cnt !== 4'd1 || vld !== 1'b1) begin
            bad++;
            $display("FAIL async_release cnt=%0d vld=%0b expected cnt=1 vld=1", cnt, vld);
        end
    endtask

    task automatic test_toggle();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step((i % 2) == 0);
            total++;
            if (vld !== logic'((i % 2) == 0) || cnt !== 4'(model_cnt)) begin
                bad++;
                $display("FAIL toggle cycle=%0d cnt=%0d vld=%0b expected cnt=%0d vld=%0b",
                         i, cnt, vld, model_cnt, (i % 2) == 0);
            end
        end
        total++;
        if (cnt !== 4'd5) begin
            bad++;
            $display("FAIL toggle_final cnt=%0d expected 5", cnt);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                #2 rst = 1'b1;
                #1;
                total++;
                if (cnt !== 4'd0 || vld !== 1'b0) begin
                    bad++;
                    $display("FAIL random_reset cycle=%0d cnt=%0d vld=%0b expected 0/0", i, cnt, vld);
                end
                @(negedge clk);
                rst = 1'b0;
                model_cnt = 0;
                model_vld = 1'b0;
`ifdef COUNTER_0_TO_9_TC_EN
                model_total = 0;
`endif
            end else begin
                step(logic'($urandom_range(0, 1)));
                total++;
                if (cnt !== 4'(model_cnt) || vld !== model_vld) begin
                    bad++;
                    $display("FAIL random cycle=%0d cnt=%0d vld=%0b expected cnt=%0d vld=%0b",
                             i, cnt, vld, model_cnt, model_vld);
                end
            end
        end
    endtask

`ifdef COUNTER_0_TO_9_TC_EN
    task automatic test_tc_chain();
        do_reset();
        for (int i = 0; i < 100; i++) begin
            en = logic'(1);
            #1;
            total++;
            if (tc !== logic'(model_cnt == 9)) begin
                bad++;
                $display("FAIL tc_comb edge=%0d tc=%0b expected %0b", i, tc, model_cnt == 9);
            end
            step(1'b1);
            total++;
            if (cnt !== 4'(model_total % 10) || cnt_tens !== 4'((model_total / 10) % 10)) begin
                bad++;
                $display("FAIL chain edge=%0d ones=%0d tens=%0d expected %0d %0d", i, cnt, cnt_tens,
                         model_total % 10, (model_total / 10) % 10);
            end
        end
        repeat (9) step(1'b1);
        en = 1'b0;
        #1;
        total++;
        if (cnt !== 4'd9 || tc !== 1'b0) begin
            bad++;
            $display("FAIL tc_en_low cnt=%0d tc=%0b expected cnt=9 tc=0", cnt, tc);
        end
        rst = 1'b1;
        en  = 1'b1;
        #1;
        total++;
        if (tc !== 1'b0) begin
            bad++;
            $display("FAIL tc_rst tc=%0b expected 0", tc);
        end
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        model_cnt = 0;
        model_vld = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_count_sequence();
        test_wrap();
        test_hold();
        test_async_reset();
        test_toggle();
        test_random();
`ifdef COUNTER_0_TO_9_TC_EN
        test_tc_chain();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
